clock_time_setter: RTL and testbench
====================================

Name: clock_time_setter

Overview:
- Upstream stage of the digital clock counter; implements the slide-switch "set time" mode.
- Debounces the raw slide switch and two pushbuttons, snapshots the running time, and lets the user edit hour, minute and second fields.
- On leaving set mode, it issues a one-cycle load strobe with the edited time, which the clock counter adopts.
- Also supplies field-select and blink outputs so the display stage can flash the field being edited.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a raw input change is accepted (20 ms at 50 MHz).
- BLINK_HALF, 12500000, cycles per half-period of the edit blink (4 Hz toggle at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- set_switch  in  1  raw slide switch; 1 = set mode
- btn_sel  in  1  raw pushbutton, active-high: advance edited field
- btn_inc  in  1  raw pushbutton, active-high: increment edited field
- cur_hour  in  5  running hour, 0-23
- cur_min  in  6  running minute, 0-59
- cur_sec  in  6  running second, 0-59
- load  out  1  one-cycle strobe: the clock counter takes set_hour/set_min/set_sec
- set_hour  out  5  edited hour
- set_min  out  6  edited minute
- set_sec  out  6  edited second
- field_sel  out  2  0 = none, 1 = hour, 2 = minute, 3 = second
- blink  out  1  display blank phase for the selected field

Behaviour:
- Clock and reset: one clock domain; all state changes on posedge clk.
- Reset values: FSM = IDLE; load = 0; set_hour/min/sec = 0; field_sel = 0; blink = 0; all debounce counters and stable levels = 0.
- Reset mid-edit abandons the edit and produces no load.
- Debounce, per input:
  - 2-flop synchroniser feeds a stable level.
  - While synced != stable, a counter increments; when it reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - Any cycle with synced == stable clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - A rising edge of stable produces a registered one-cycle press pulse (sel_p, inc_p).
  - Latency from raw edge to pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE:
  - field_sel = 0; press pulses are ignored.
  - If debounced switch = 1: snapshot cur_* into set_*, then go to EDIT_HR.
  - Entry is level-based, so a switch already high at reset release enters edit after debounce.
- EDIT_x:
  - field_sel = 1/2/3 respectively.
  - inc_p increments the field modulo its range: hour 23 -> 0, minute/second 59 -> 0.
  - sel_p advances HR -> MIN -> SEC -> HR.
  - Both pulses in the same cycle: increment the current field first, then advance.
  - Unedited fields hold their snapshot values.
- Exit from EDIT_x:
  - Debounced switch = 0 moves to COMMIT.
  - A press pulse arriving in the same cycle as the switch fall is discarded.
- COMMIT: load = 1 for exactly this cycle, set_* valid; next state IDLE. set_* hold their values afterwards.
- Blink:
  - Counter runs only in EDIT states; blink toggles each BLINK_HALF cycles.
  - Counter and blink clear to 0 on every press pulse, so the field is visible immediately after an edit.
  - blink = 0 in IDLE and COMMIT.
- Widths:
  - Field arithmetic is done in field width, with an explicit compare before wrap; no out-of-range value is ever output.
  - Counter widths are $clog2 of the parameter, minimum 1.

Decomposition:
- Shared package clock_pkg:
  - Constants HOUR_MAX = 23 and MIN_SEC_MAX = 59.
  - Field-select encoding FIELD_NONE / FIELD_HR / FIELD_MIN / FIELD_SEC.
  - FSM state enum.
- One sub-module, input_debouncer, parameterised by DEBOUNCE_CYCLES; outputs stable level and rise pulse. Instantiated three times (switch, sel, inc).

Test Plan (bench overrides DEBOUNCE_CYCLES = 4, BLINK_HALF = 8):
1. Bounce rejection: btn_inc toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one inc_p, 7 cycles after the final rise.
2. Enter and commit without edits: cur = 12:34:56, switch high, then low -> load pulses once, 1 cycle wide, with set = 12:34:56.
3. Hour wrap: snapshot hour 22, three inc presses in EDIT_HR, then exit -> load with set_hour = 1, minute and second unchanged.
4. Field cycling and wrap: sel to MIN, set minute 59 then inc -> 0; sel twice -> field_sel sequence 2, 3, 1.
5. Simultaneous events: sel and inc pulses in the same cycle at EDIT_SEC with sec = 59 -> sec = 0, field_sel = 1. A press coinciding with the switch fall -> value unchanged, load next cycle.
6. Reset mid-edit: assert reset in EDIT_MIN -> next cycle load = 0, field_sel = 0, blink = 0, set_* = 0, and no load pulse follows.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: field limits, field-select encoding and set-mode FSM states shared by the clock setter.
package clock_pkg;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_SEC_MAX = 6'd59;
  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;
  typedef enum logic [2:0] {
    IDLE,
    EDIT_HR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_e;
  function automatic logic is_edit(input state_e s);
    return s == EDIT_HR || s == EDIT_MIN || s == EDIT_SEC;
  endfunction
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser plus stability counter; emits the debounced level and a registered rise pulse.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic stable_q, stable_d, prev_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // any cycle where the synced input agrees with the stable level restarts the count
  always_comb begin
    cnt_d = (sync_q[1] == stable_q || cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    stable_d = (sync_q[1] != stable_q && cnt_q == CNT_LAST) ? sync_q[1] : stable_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      stable_q <= 1'b0;
      cnt_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      prev_q <= stable_q;
      rise_q <= stable_q & ~prev_q;
    end
  end
  assign level_o = stable_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/clock_time_setter.sv
// clock_time_setter: set-mode editor that snapshots the running time, edits h/m/s fields and strobes load on exit.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_switch,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [1:0] field_sel,
  output logic       blink
);
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  state_e state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d;
  logic sw_lvl, sw_rise, sel_lvl, sel_p, inc_lvl, inc_p, press, edit_d;
  logic unused_levels;
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk(clk), .reset(reset), .raw_i(set_switch), .level_o(sw_lvl), .rise_o(sw_rise)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .reset(reset), .raw_i(btn_sel), .level_o(sel_lvl), .rise_o(sel_p)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .raw_i(btn_inc), .level_o(inc_lvl), .rise_o(inc_p)
  );
  assign unused_levels = ^{sw_rise, sel_lvl, inc_lvl};
  always_comb begin
    state_d = state_q;
    hour_d = hour_q;
    min_d = min_q;
    sec_d = sec_q;
    unique case (state_q)
      IDLE: if (sw_lvl) begin
        hour_d = cur_hour;
        min_d = cur_min;
        sec_d = cur_sec;
        state_d = EDIT_HR;
      end
      EDIT_HR, EDIT_MIN, EDIT_SEC: begin
        // a switch fall wins over any press pulse in the same cycle
        if (!sw_lvl) state_d = COMMIT;
        else begin
          if (inc_p && state_q == EDIT_HR) hour_d = hour_q == HOUR_MAX ? 5'd0 : hour_q + 5'd1;
          if (inc_p && state_q == EDIT_MIN) min_d = min_q == MIN_SEC_MAX ? 6'd0 : min_q + 6'd1;
          if (inc_p && state_q == EDIT_SEC) sec_d = sec_q == MIN_SEC_MAX ? 6'd0 : sec_q + 6'd1;
          if (sel_p) state_d = state_q == EDIT_HR ? EDIT_MIN : state_q == EDIT_MIN ? EDIT_SEC : EDIT_HR;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // keyed on the next state so blink is already low in the first non-edit cycle
  always_comb begin
    press = sel_p | inc_p;
    edit_d = is_edit(state_d);
    bcnt_d = (!edit_d || press || bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
    blink_d = (!edit_d || press) ? 1'b0 : bcnt_q == BLINK_LAST ? ~blink_q : blink_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hour_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      bcnt_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q <= hour_d;
      min_q <= min_d;
      sec_q <= sec_d;
      bcnt_q <= bcnt_d;
      blink_q <= blink_d;
    end
  end
  assign load = state_q == COMMIT;
  assign set_hour = hour_q;
  assign set_min = min_q;
  assign set_sec = sec_q;
  assign blink = blink_q;
  assign field_sel = state_q == EDIT_HR ? FIELD_HR : state_q == EDIT_MIN ? FIELD_MIN :
                     state_q == EDIT_SEC ? FIELD_SEC : FIELD_NONE;
endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: directed scenarios for the clock setter with short debounce and blink periods.
module tb_clock_time_setter;
  logic clk = 1'b0, reset = 1'b1, set_switch = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic load, blink;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic [1:0] field_sel;
  int checks = 0, errors = 0;

  clock_time_setter #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
    .clk(clk), .reset(reset), .set_switch(set_switch), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic i);
    btn_sel = s;
    btn_inc = i;
    step(8);
    btn_sel = 1'b0;
    btn_inc = 1'b0;
    step(8);
  endtask

  task automatic enter(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h;
    cur_min = m;
    cur_sec = s;
    set_switch = 1'b1;
    step(10);
  endtask

  task automatic exit_capture(output int first, output int n, output logic [4:0] h,
                              output logic [5:0] m, output logic [5:0] s);
    first = -1; n = 0; h = '0; m = '0; s = '0;
    set_switch = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (load) begin
        n++;
        if (first < 0) begin first = i; h = set_hour; m = set_min; s = set_sec; end
      end
    end
  endtask

  task automatic test_reset;
    step(3);
    reset = 1'b0;
    step(1);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", load); end
    checks++; if ({set_hour, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL reset_set got %0d:%0d:%0d want 0:0:0", set_hour, set_min, set_sec); end
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL reset_field got %0d want 0", field_sel); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %0b want 0", blink); end
  endtask

  task automatic test_bounce;
    int pulses = 0, at = -1;
    for (int k = 0; k < 5; k++) begin
      btn_inc = 1'b1;
      for (int j = 0; j < 2; j++) begin step(1); if (dut.inc_p) pulses++; end
      btn_inc = 1'b0;
      for (int j = 0; j < 2; j++) begin step(1); if (dut.inc_p) pulses++; end
    end
    btn_inc = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (dut.inc_p) begin pulses++; if (at < 0) at = i; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_count got %0d want 1", pulses); end
    checks++; if (at !== 7) begin errors++; $display("FAIL bounce_latency got %0d want 7", at); end
    btn_inc = 1'b0;
    step(10);
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL bounce_idle_field got %0d want 0", field_sel); end
  endtask

  task automatic test_commit_plain;
    int first, n;
    logic [4:0] h;
    logic [5:0] m, s;
    enter(5'd12, 6'd34, 6'd56);
    checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL plain_field got %0d want 1", field_sel); end
    exit_capture(first, n, h, m, s);
    checks++; if (n !== 1) begin errors++; $display("FAIL plain_load_count got %0d want 1", n); end
    checks++; if (first !== 7) begin errors++; $display("FAIL plain_load_cycle got %0d want 7", first); end
    checks++; if ({h, m, s} !== {5'd12, 6'd34, 6'd56}) begin errors++; $display("FAIL plain_value got %0d:%0d:%0d want 12:34:56", h, m, s); end
    checks++; if (field_sel !== 2'd0 || {set_hour, set_min, set_sec} !== {5'd12, 6'd34, 6'd56}) begin errors++; $display("FAIL plain_after got field %0d %0d:%0d:%0d want field 0 12:34:56", field_sel, set_hour, set_min, set_sec); end
  endtask

  task automatic test_hour_wrap;
    int first, n;
    logic [4:0] h;
    logic [5:0] m, s;
    enter(5'd22, 6'd10, 6'd20);
    cur_min = 6'd45;
    cur_sec = 6'd3;
    press(1'b0, 1'b1);
    checks++; if (set_hour !== 5'd23) begin errors++; $display("FAIL hour_inc got %0d want 23", set_hour); end
    press(1'b0, 1'b1);
    checks++; if (set_hour !== 5'd0) begin errors++; $display("FAIL hour_wrap got %0d want 0", set_hour); end
    press(1'b0, 1'b1);
    exit_capture(first, n, h, m, s);
    checks++; if (n !== 1 || {h, m, s} !== {5'd1, 6'd10, 6'd20}) begin errors++; $display("FAIL hour_load got n=%0d %0d:%0d:%0d want n=1 1:10:20", n, h, m, s); end
  endtask

  task automatic test_field_cycle;
    int first, n;
    logic [4:0] h;
    logic [5:0] m, s;
    enter(5'd5, 6'd58, 6'd30);
    press(1'b1, 1'b0);
    checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL cycle_min got %0d want 2", field_sel); end
    press(1'b0, 1'b1);
    checks++; if (set_min !== 6'd59) begin errors++; $display("FAIL min_inc got %0d want 59", set_min); end
    press(1'b0, 1'b1);
    checks++; if (set_min !== 6'd0 || set_hour !== 5'd5) begin errors++; $display("FAIL min_wrap got %0d:%0d want 5:0", set_hour, set_min); end
    press(1'b1, 1'b0);
    checks++; if (field_sel !== 2'd3) begin errors++; $display("FAIL cycle_sec got %0d want 3", field_sel); end
    press(1'b1, 1'b0);
    checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL cycle_hr got %0d want 1", field_sel); end
    exit_capture(first, n, h, m, s);
    checks++; if (n !== 1 || {h, m, s} !== {5'd5, 6'd0, 6'd30}) begin errors++; $display("FAIL cycle_load got n=%0d %0d:%0d:%0d want n=1 5:0:30", n, h, m, s); end
  endtask

  task automatic test_simultaneous;
    int first = -1, n = 0;
    logic [4:0] h = '0;
    logic [5:0] s = '0;
    enter(5'd7, 6'd8, 6'd59);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++; if (field_sel !== 2'd3 || set_sec !== 6'd59) begin errors++; $display("FAIL simul_setup got field %0d sec %0d want field 3 sec 59", field_sel, set_sec); end
    press(1'b1, 1'b1);
    checks++; if (set_sec !== 6'd0 || field_sel !== 2'd1) begin errors++; $display("FAIL simul_both got sec %0d field %0d want sec 0 field 1", set_sec, field_sel); end
    btn_inc = 1'b1;
    step(1);
    set_switch = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (load) begin
        n++;
        if (first < 0) begin first = i; h = set_hour; s = set_sec; end
      end
    end
    checks++; if (n !== 1 || first !== 7) begin errors++; $display("FAIL simul_exit_load got n=%0d at %0d want n=1 at 7", n, first); end
    checks++; if (h !== 5'd7 || s !== 6'd0) begin errors++; $display("FAIL simul_exit_value got %0d:%0d want 7:0", h, s); end
    btn_inc = 1'b0;
    step(10);
  endtask

  task automatic test_blink_and_reset;
    int loads = 0;
    enter(5'd3, 6'd4, 6'd5);
    press(1'b1, 1'b0);
    btn_inc = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      if (i == 10) btn_inc = 1'b0;
      if (i == 15) begin checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_hold got %0b want 0", blink); end end
      if (i == 16) begin checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_on got %0b want 1", blink); end end
      if (i == 24) begin checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_off got %0b want 0", blink); end end
      if (i == 32) begin checks++; if (blink !== 1'b1 || set_min !== 6'd5) begin errors++; $display("FAIL blink_again got blink %0b min %0d want blink 1 min 5", blink, set_min); end end
    end
    checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL midedit_field got %0d want 2", field_sel); end
    reset = 1'b1;
    set_switch = 1'b0;
    step(1);
    checks++; if (load !== 1'b0 || field_sel !== 2'd0 || blink !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got load %0b field %0d blink %0b want 0 0 0", load, field_sel, blink); end
    checks++; if ({set_hour, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL midreset_set got %0d:%0d:%0d want 0:0:0", set_hour, set_min, set_sec); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin step(1); if (load) loads++; end
    checks++; if (loads !== 0) begin errors++; $display("FAIL midreset_noload got %0d want 0", loads); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_commit_plain;
    test_hour_wrap;
    test_field_cycle;
    test_simultaneous;
    test_blink_and_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
